sap_wbus_reg: RTL and testbench

- Parametrised, registered W-bus for the SAP-class datapath.
- Replaces the fixed control-word case decode with per-source one-hot drive enables and a pipeline register on the bus.
- Adds narrow-source zero-extension, a hold-last/zero idle mode, multi-driver conflict detection with a sticky error, and a transfer counter for debug.
- Sits between the source units (PC, RAM, IR, ALU, ACC) and the sink units (MAR, IR, OPR, B, ACC).

---
 rtl/sap_wbus_reg.sv | 107 ++++++++++
 tb/tb_sap_wbus_reg.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sap_wbus_reg.sv
// Registered SAP W-bus: priority pick of one-hot drivers, narrow-source
// zero-extension, idle hold/zero, conflict flagging and a transfer counter.
module sap_wbus_reg #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 4,
    parameter int NSRC      = 5,
    parameter bit HOLD_LAST = 1'b0,
    parameter int CNT_W     = 16,
    localparam int SRC_W    = (NSRC > 1) ? $clog2(NSRC) : 1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [NSRC*DATA_W-1:0] src_data_i,
    input  logic [NSRC-1:0]        src_en_i,
    input  logic [NSRC-1:0]        src_narrow_i,
    input  logic                   err_clr_i,
    output logic [DATA_W-1:0]      bus_out_o,
    output logic [ADDR_W-1:0]      mar_out_o,
    output logic                   bus_valid_o,
    output logic [SRC_W-1:0]       bus_src_o,
    output logic                   conflict_o,
    output logic                   err_sticky_o,
    output logic [CNT_W-1:0]       xfer_cnt_o
);

    logic [DATA_W-1:0] bus_q, bus_d;
    logic              valid_q, valid_d;
    logic [SRC_W-1:0]  src_q, src_d;
    logic              conf_q, conf_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [DATA_W-1:0] word;
    logic [SRC_W-1:0]  sel;
    logic              sel_narrow;
    logic              any_en;
    logic              multi_en;

    // Descending scan so the lowest set index wins.
    always_comb begin
        word       = '0;
        sel        = '0;
        sel_narrow = 1'b0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (src_en_i[i]) begin
                word       = src_data_i[i*DATA_W +: DATA_W];
                sel        = SRC_W'(i);
                sel_narrow = src_narrow_i[i];
            end
        end
        if (sel_narrow) begin
            for (int b = ADDR_W; b < DATA_W; b++) begin
                word[b] = 1'b0;
            end
        end
    end

    assign any_en   = |src_en_i;
    assign multi_en = |(src_en_i & (src_en_i - NSRC'(1)));

    always_comb begin
        bus_d   = HOLD_LAST ? bus_q : '0;
        valid_d = 1'b0;
        src_d   = src_q;
        cnt_d   = cnt_q;
        conf_d  = multi_en;
        err_d   = err_q;
        if (any_en) begin
            bus_d   = word;
            valid_d = 1'b1;
            src_d   = sel;
            cnt_d   = cnt_q + CNT_W'(1);
        end
        if (multi_en) begin
            err_d = 1'b1;
        end else if (err_clr_i) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            bus_q   <= '0;
            valid_q <= 1'b0;
            src_q   <= '0;
            conf_q  <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            bus_q   <= bus_d;
            valid_q <= valid_d;
            src_q   <= src_d;
            conf_q  <= conf_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus_out_o    = bus_q;
    assign mar_out_o    = bus_q[ADDR_W-1:0];
    assign bus_valid_o  = valid_q;
    assign bus_src_o    = src_q;
    assign conflict_o   = conf_q;
    assign err_sticky_o = err_q;
    assign xfer_cnt_o   = cnt_q;

endmodule

// File: tb/tb_sap_wbus_reg.sv
// Bench for sap_wbus_reg: two variants (zero-idle/CNT_W=4, hold-last/CNT_W=16)
// checked against a behavioural model every cycle plus directed literals.
module tb_sap_wbus_reg;

    localparam int NSRC = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [39:0] src_data = '0;
    logic [4:0]  src_en = '0;
    logic [4:0]  src_narrow = '0;
    logic        err_clr = 1'b0;

    logic [7:0]  bus_out [2];
    logic [3:0]  mar_out [2];
    logic        bus_valid [2];
    logic [2:0]  bus_src [2];
    logic        conflict [2];
    logic        err_sticky [2];
    logic [3:0]  cnt_a;
    logic [15:0] cnt_b;

    int checks = 0;
    int errors = 0;
    bit done = 1'b0;

    always #5 clk = ~clk;

    sap_wbus_reg #(.DATA_W(8), .ADDR_W(4), .NSRC(5), .HOLD_LAST(1'b0), .CNT_W(4)) dut_a (
        .clk_i(clk), .rst_i(rst), .src_data_i(src_data), .src_en_i(src_en),
        .src_narrow_i(src_narrow), .err_clr_i(err_clr),
        .bus_out_o(bus_out[0]), .mar_out_o(mar_out[0]), .bus_valid_o(bus_valid[0]),
        .bus_src_o(bus_src[0]), .conflict_o(conflict[0]), .err_sticky_o(err_sticky[0]),
        .xfer_cnt_o(cnt_a)
    );

    sap_wbus_reg #(.DATA_W(8), .ADDR_W(4), .NSRC(5), .HOLD_LAST(1'b1), .CNT_W(16)) dut_b (
        .clk_i(clk), .rst_i(rst), .src_data_i(src_data), .src_en_i(src_en),
        .src_narrow_i(src_narrow), .err_clr_i(err_clr),
        .bus_out_o(bus_out[1]), .mar_out_o(mar_out[1]), .bus_valid_o(bus_valid[1]),
        .bus_src_o(bus_src[1]), .conflict_o(conflict[1]), .err_sticky_o(err_sticky[1]),
        .xfer_cnt_o(cnt_b)
    );

    // Behavioural model
    int m_bus [2];
    int m_valid [2];
    int m_src [2];
    int m_conf [2];
    int m_err [2];
    int m_cnt [2];
    int hold [2] = '{0, 1};
    int cmod [2] = '{16, 65536};

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int d = 0; d < 2; d++) begin
                m_bus[d] = 0; m_valid[d] = 0; m_src[d] = 0;
                m_conf[d] = 0; m_err[d] = 0; m_cnt[d] = 0;
            end
        end else begin
            int first;
            int n;
            first = -1;
            n = 0;
            for (int i = 0; i < NSRC; i++) begin
                if (src_en[i]) begin
                    n++;
                    if (first < 0) first = i;
                end
            end
            for (int d = 0; d < 2; d++) begin
                if (first >= 0) begin
                    int w;
                    w = int'(src_data[first*8 +: 8]);
                    if (src_narrow[first]) w = w % 16;
                    m_bus[d] = w;
                    m_src[d] = first;
                    m_valid[d] = 1;
                    m_cnt[d] = (m_cnt[d] + 1) % cmod[d];
                end else begin
                    m_valid[d] = 0;
                    if (hold[d] == 0) m_bus[d] = 0;
                end
                m_conf[d] = (n >= 2) ? 1 : 0;
                if (n >= 2) m_err[d] = 1;
                else if (err_clr) m_err[d] = 0;
            end
        end
    end

    task automatic cmp(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!done) begin
            for (int d = 0; d < 2; d++) begin
                cmp($sformatf("bus_out[%0d]", d), int'(bus_out[d]), m_bus[d]);
                cmp($sformatf("mar_out[%0d]", d), int'(mar_out[d]), m_bus[d] % 16);
                cmp($sformatf("bus_valid[%0d]", d), int'(bus_valid[d]), m_valid[d]);
                cmp($sformatf("bus_src[%0d]", d), int'(bus_src[d]), m_src[d]);
                cmp($sformatf("conflict[%0d]", d), int'(conflict[d]), m_conf[d]);
                cmp($sformatf("err_sticky[%0d]", d), int'(err_sticky[d]), m_err[d]);
            end
            cmp("xfer_cnt_a", int'(cnt_a), m_cnt[0]);
            cmp("xfer_cnt_b", int'(cnt_b), m_cnt[1]);
        end
    end

    // Apply inputs just after an edge, then step to just after the next edge.
    task automatic step(input logic [4:0] en, input logic [39:0] data,
                        input logic [4:0] nar, input logic clr);
        src_en = en;
        src_data = data;
        src_narrow = nar;
        err_clr = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(5'b0, $urandom, 5'b0, 1'b0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        @(posedge clk);
        #1;
        // Async reset mid-cycle with a transfer pending
        rst = 1'b0;
        step(5'b00001, 40'h00000000AB, 5'b0, 1'b0);
        src_en = 5'b00001;
        #3;
        rst = 1'b1;
        #1;
        cmp("rst_bus", int'(bus_out[0]), 0);
        cmp("rst_valid", int'(bus_valid[0]), 0);
        cmp("rst_cnt", int'(cnt_a), 0);
        cmp("rst_bus_hold", int'(bus_out[1]), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle();
        cmp("post_rst_bus", int'(bus_out[0]), 0);
        cmp("post_rst_bus_hold", int'(bus_out[1]), 0);

        // Narrow source zero-extension
        step(5'b00001, 40'h11223344A7, 5'b00001, 1'b0);
        cmp("narrow_bus", int'(bus_out[0]), 8'h07);
        cmp("narrow_mar", int'(mar_out[0]), 4'h7);
        cmp("narrow_valid", int'(bus_valid[0]), 1);
        cmp("narrow_src", int'(bus_src[0]), 0);
        cmp("narrow_cnt", int'(cnt_a), 1);

        // Back-to-back full-width
        step(5'b00010, 40'h00F1000000 | 40'h0000003C00, 5'b0, 1'b0);
        cmp("b2b_bus0", int'(bus_out[0]), 8'h3C);
        cmp("b2b_valid0", int'(bus_valid[0]), 1);
        step(5'b01000, 40'h00F1000000, 5'b0, 1'b0);
        cmp("b2b_bus1", int'(bus_out[0]), 8'hF1);
        cmp("b2b_src1", int'(bus_src[0]), 3);
        cmp("b2b_valid1", int'(bus_valid[0]), 1);
        cmp("b2b_cnt", int'(cnt_a), 3);

        // Idle modes
        step(5'b00100, 40'h0000550000, 5'b0, 1'b0);
        idle();
        cmp("idle_zero_bus", int'(bus_out[0]), 0);
        cmp("idle_zero_valid", int'(bus_valid[0]), 0);
        cmp("idle_hold_bus", int'(bus_out[1]), 8'h55);
        cmp("idle_hold_valid", int'(bus_valid[1]), 0);
        cmp("idle_src_hold", int'(bus_src[0]), 2);

        // Conflict and sticky error
        step(5'b00110, 40'h0000221100, 5'b0, 1'b0);
        cmp("conf_bus", int'(bus_out[0]), 8'h11);
        cmp("conf_src", int'(bus_src[0]), 1);
        cmp("conf_flag", int'(conflict[0]), 1);
        cmp("conf_err", int'(err_sticky[0]), 1);
        idle();
        cmp("conf_one_cycle", int'(conflict[0]), 0);
        cmp("err_held", int'(err_sticky[0]), 1);
        step(5'b00001, 40'h01, 5'b0, 1'b1);
        cmp("err_cleared", int'(err_sticky[0]), 0);
        step(5'b10001, 40'h01, 5'b0, 1'b1);
        cmp("err_set_wins", int'(err_sticky[0]), 1);
        cmp("err_set_conf", int'(conflict[0]), 1);

        // Counter wrap with CNT_W=4
        do_reset();
        for (int i = 0; i < 16; i++) step(5'b00100, $urandom, 5'b0, 1'b0);
        cmp("wrap16_a", int'(cnt_a), 0);
        cmp("wrap16_b", int'(cnt_b), 16);
        step(5'b00100, $urandom, 5'b0, 1'b0);
        cmp("wrap17_a", int'(cnt_a), 1);

        // Randomised traffic
        for (int i = 0; i < 600; i++) begin
            logic [4:0] en;
            int r;
            r = $urandom_range(0, 9);
            if (r < 6) en = 5'(1 << $urandom_range(0, 4));
            else if (r < 8) en = 5'b0;
            else en = 5'($urandom);
            step(en, {$urandom, 8'($urandom)}, 5'($urandom),
                 ($urandom_range(0, 4) == 0) ? 1'b1 : 1'b0);
            if ($urandom_range(0, 60) == 0) begin
                #3;
                rst = 1'b1;
                @(posedge clk);
                #1;
                rst = 1'b0;
            end
        end

        @(negedge clk);
        done = 1'b1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
